// File: rtl/serial_adder_pkg.sv
// Shared definitions for the adder family: FSM encoding and default operand width.
package adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    localparam int ADD_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_FIN  = ST_FIN
    } adder_state_e;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle of the bit-serial adder, plus the FSM state for observation.
// Handshake: START is a request sampled only while BUSY=0; DONE is a one-cycle
// pulse meaning S/COUT were just updated and remain stable until the next DONE.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             START;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CIN;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] S;
    logic             COUT;
    logic [1:0]       dbg_state;

    modport master (
        output START, A, B, CIN,
        input  BUSY, DONE, S, COUT, dbg_state
    );

    modport slave (
        input  START, A, B, CIN,
        output BUSY, DONE, S, COUT, dbg_state
    );
endinterface

// File: rtl/half_adder.sv
// Single-bit half adder, the base cell of the adder family.
module half_adder (
    input  logic A,
    input  logic B,
    output logic S,
    output logic COUT
);
    assign S    = A ^ B;
    assign COUT = A & B;
endmodule

// File: rtl/serial_adder_full_adder.sv
// Full adder composed from two half adders; carries can never both be set.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic CIN,
    output logic S,
    output logic COUT
);
    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (
        .A    (A),
        .B    (B),
        .S    (s0),
        .COUT (c0)
    );

    half_adder u_ha1 (
        .A    (s0),
        .B    (CIN),
        .S    (S),
        .COUT (c1)
    );

    assign COUT = c0 | c1;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one operand bit pair per clock, LSB first,
// result registered on the last RUN edge and announced by a DONE pulse.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH_DEF
) (
    input logic           CLK,
    input logic           RST_N,
    serial_adder_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    adder_state_e state;
    adder_state_e state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] s_q;
    logic             cout_q;

    logic fa_s;
    logic fa_cout;
    logic last_bit;

    full_adder u_fa (
        .A    (a_sh[0]),
        .B    (b_sh[0]),
        .CIN  (carry),
        .S    (fa_s),
        .COUT (fa_cout)
    );

    assign last_bit = (cnt == CNT_LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.START) state_nxt = S_RUN;
            S_RUN:   if (last_bit)  state_nxt = S_FIN;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operands are only captured in IDLE, so input activity while busy is inert.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            s_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.START) begin
                        a_sh   <= bus.A;
                        b_sh   <= bus.B;
                        carry  <= bus.CIN;
                        sum_sh <= '0;
                        cnt    <= '0;
                    end
                end
                S_RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= fa_cout;
                    sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
                    cnt    <= cnt + CW'(1);
                    // Publish straight from the adder so S never shows a partial sum.
                    if (last_bit) begin
                        s_q    <= {fa_s, sum_sh[WIDTH-1:1]};
                        cout_q <= fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.BUSY      = (state != S_IDLE);
    assign bus.DONE      = (state == S_FIN);
    assign bus.S         = s_q;
    assign bus.COUT      = cout_q;
    assign bus.dbg_state = state;

endmodule
